// File: rtl/banyan_ingress_sched.sv
// Ingress buffering and conflict-free scheduling for a 4x4 banyan fabric.
// Four FWFT FIFOs feed a round-robin picker; the chosen words and element selects are registered.
module banyan_ingress_sched #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        in_valid,
   output logic [3:0]        in_ready,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [DATA_W-1:0] in_data3,
   input  logic [1:0]        in_dest0,
   input  logic [1:0]        in_dest1,
   input  logic [1:0]        in_dest2,
   input  logic [1:0]        in_dest3,
   input  logic              sw_ready,
   output logic [3:0]        sel,
   output logic [DATA_W-1:0] sw_in0,
   output logic [DATA_W-1:0] sw_in1,
   output logic [DATA_W-1:0] sw_in2,
   output logic [DATA_W-1:0] sw_in3,
   output logic [3:0]        sw_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + 2;

   logic [DATA_W-1:0] in_data_a [4];
   logic [1:0]        in_dest_a [4];

   logic [EW-1:0]     mem_q [4][DEPTH];
   logic [EW-1:0]     mem_d [4][DEPTH];
   logic [AW:0]       wr_ptr_q [4];
   logic [AW:0]       wr_ptr_d [4];
   logic [AW:0]       rd_ptr_q [4];
   logic [AW:0]       rd_ptr_d [4];

   logic [3:0]        empty;
   logic [3:0]        full;
   logic [3:0]        push;
   logic [EW-1:0]     head_word [4];
   logic [1:0]        head_dest [4];
   logic [DATA_W-1:0] head_data [4];

   logic [1:0]        ptr_q;
   logic [1:0]        ptr_d;
   logic [3:0]        grant;
   logic [1:0]        visit;
   logic [1:0]        first_port;
   logic              first_found;
   logic              ok;

   logic [3:0]        sel_n;
   logic [3:0]        sel_q;
   logic [3:0]        sel_d;
   logic [3:0]        sw_valid_q;
   logic [3:0]        sw_valid_d;
   logic [DATA_W-1:0] sw_in_q [4];
   logic [DATA_W-1:0] sw_in_d [4];

   // Two heads block each other if they leave one stage-1 element on the same side,
   // or if they want the same fabric output (same stage-2 element output).
   function automatic logic collide(input logic ea, input logic [1:0] da,
                                    input logic eb, input logic [1:0] db);
      return ((ea == eb) && (da[1] == db[1])) || (da == db);
   endfunction

   assign in_data_a[0] = in_data0;
   assign in_data_a[1] = in_data1;
   assign in_data_a[2] = in_data2;
   assign in_data_a[3] = in_data3;
   assign in_dest_a[0] = in_dest0;
   assign in_dest_a[1] = in_dest1;
   assign in_dest_a[2] = in_dest2;
   assign in_dest_a[3] = in_dest3;

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         empty[p]     = (wr_ptr_q[p] == rd_ptr_q[p]);
         full[p]      = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                        (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
         head_word[p] = mem_q[p][rd_ptr_q[p][AW-1:0]];
         head_dest[p] = head_word[p][EW-1:DATA_W];
         head_data[p] = head_word[p][DATA_W-1:0];
      end
   end

   assign in_ready = ~full;

   // FIFO write/read pointer advance; pops are exactly this cycle's grants.
   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < 4; p++) begin
         push[p]     = in_valid[p] & ~full[p];
         wr_ptr_d[p] = wr_ptr_q[p] + {{AW{1'b0}}, push[p]};
         rd_ptr_d[p] = rd_ptr_q[p] + {{AW{1'b0}}, grant[p]};
         if (push[p]) begin
            mem_d[p][wr_ptr_q[p][AW-1:0]] = {in_dest_a[p], in_data_a[p]};
         end
      end
   end

   // Round-robin greedy pick starting at ptr_q.
   always_comb begin
      grant       = '0;
      visit       = '0;
      ok          = 1'b0;
      first_port  = '0;
      first_found = 1'b0;
      if (sw_ready) begin
         for (int i = 0; i < 4; i++) begin
            visit = ptr_q + 2'(i);
            ok    = ~empty[visit];
            for (int j = 0; j < 4; j++) begin
               if (grant[j] && collide(visit[1], head_dest[visit], 1'(j / 2), head_dest[j])) begin
                  ok = 1'b0;
               end
            end
            if (ok) begin
               grant[visit] = 1'b1;
               if (!first_found) begin
                  first_found = 1'b1;
                  first_port  = visit;
               end
            end
         end
      end
      ptr_d = first_found ? first_port + 2'd1 : ptr_q;
   end

   // Element selects: stage 1 from the lane position vs d[1]; stage 2 element 2+d[1]
   // sees words from element 0 on its upper input and from element 1 on its lower input.
   always_comb begin
      sel_n = '0;
      if (grant[0])      sel_n[0] = head_dest[0][1];
      else if (grant[1]) sel_n[0] = ~head_dest[1][1];
      if (grant[2])      sel_n[1] = head_dest[2][1];
      else if (grant[3]) sel_n[1] = ~head_dest[3][1];
      for (int k = 0; k < 2; k++) begin
         if (grant[0] && (head_dest[0][1] == 1'(k)))      sel_n[2+k] = head_dest[0][0];
         else if (grant[1] && (head_dest[1][1] == 1'(k))) sel_n[2+k] = head_dest[1][0];
         else if (grant[2] && (head_dest[2][1] == 1'(k))) sel_n[2+k] = ~head_dest[2][0];
         else if (grant[3] && (head_dest[3][1] == 1'(k))) sel_n[2+k] = ~head_dest[3][0];
      end
   end

   always_comb begin
      sel_d      = sel_q;
      sw_valid_d = sw_valid_q;
      sw_in_d    = sw_in_q;
      if (sw_ready) begin
         sel_d      = sel_n;
         sw_valid_d = grant;
         for (int p = 0; p < 4; p++) begin
            sw_in_d[p] = grant[p] ? head_data[p] : '0;
         end
      end
   end

   // Stage boundary: FIFO state, scheduler pointer and fabric output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         sel_q      <= '0;
         sw_valid_q <= '0;
         for (int p = 0; p < 4; p++) begin
            wr_ptr_q[p] <= '0;
            rd_ptr_q[p] <= '0;
            sw_in_q[p]  <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         sw_valid_q <= sw_valid_d;
         for (int p = 0; p < 4; p++) begin
            wr_ptr_q[p] <= wr_ptr_d[p];
            rd_ptr_q[p] <= rd_ptr_d[p];
            sw_in_q[p]  <= sw_in_d[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign sel      = sel_q;
   assign sw_valid = sw_valid_q;
   assign sw_in0   = sw_in_q[0];
   assign sw_in1   = sw_in_q[1];
   assign sw_in2   = sw_in_q[2];
   assign sw_in3   = sw_in_q[3];

endmodule
